// File: rtl/approx_adder_error_monitor.sv
// approx_adder_error_monitor: drives pseudo-random operand pairs into a combinational approximate adder and accumulates error statistics
// Ports:
//   clk, rst_n          clock (rising edge) and synchronous active-low reset
//   start, abort        begin a run (IDLE/DONE only), end a run early (RUN/DRAIN only)
//   seed                LFSR seed captured on an accepted start; 0 is replaced by 1
//   op_a, op_b          operands to the netlist (op_a[15-i] -> g<i>, op_b[15-i] -> g<16+i>)
//   op_valid            operands carry a live sample
//   approx_sum          netlist sum; [16] is the carry-out (g251), [0] is g235
//   busy, done          run in progress / statistics final
//   err_count, err_sum, err_max   mismatch count, sum and maximum of absolute error
module approx_adder_error_monitor #(
   parameter int WIDTH       = 16,
   parameter int NUM_SAMPLES = 4096,
   parameter int CNT_W       = 17
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [31:0]            seed,
   output logic [WIDTH-1:0]       op_a,
   output logic [WIDTH-1:0]       op_b,
   output logic                   op_valid,
   input  logic [WIDTH:0]         approx_sum,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       err_count,
   output logic [WIDTH+CNT_W:0]   err_sum,
   output logic [WIDTH:0]         err_max
);
   localparam int SW = WIDTH + CNT_W + 1;
   typedef enum logic [1:0] {s_idle, s_run, s_drain, s_done} state_t;
   state_t state, state_nx;
   logic [31:0] lfsr, lfsr_nx, last;
   logic [CNT_W-1:0] cnt;
   logic dcnt, v1, go, stop, last_smp;
   logic [WIDTH:0] exact, approx, absdiff;
   logic [WIDTH+1:0] diff;
   always_comb begin
      go       = (state == s_idle || state == s_done) && start;
      stop     = (state == s_run || state == s_drain) && abort;
      last_smp = cnt == CNT_W'(NUM_SAMPLES - 1);
      state_nx = go ? s_run :
                 stop ? s_idle :
                 (state == s_run && last_smp) ? s_drain :
                 (state == s_drain && dcnt) ? s_done : state;
      op_valid = state == s_run;
      busy     = state == s_run || state == s_drain;
      done     = state == s_done;
      // operands track the LFSR while issuing and freeze on the last issued pair otherwise
      op_a     = op_valid ? lfsr[31 -: WIDTH] : last[31 -: WIDTH];
      op_b     = op_valid ? lfsr[15 -: WIDTH] : last[15 -: WIDTH];
      lfsr_nx  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h80200003 : 32'h0);
      // one extra bit so the sign of exact - approx is visible
      diff     = {1'b0, exact} - {1'b0, approx};
      absdiff  = diff[WIDTH+1] ? ~diff[WIDTH:0] + 1'b1 : diff[WIDTH:0];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= s_idle;
         lfsr      <= 32'h1;
         last      <= '0;
         cnt       <= '0;
         dcnt      <= 1'b0;
         v1        <= 1'b0;
         exact     <= '0;
         approx    <= '0;
         err_count <= '0;
         err_sum   <= '0;
         err_max   <= '0;
      end else begin
         state  <= state_nx;
         dcnt   <= (state == s_drain) ? ~dcnt : 1'b0;
         // an abort flushes the sample sitting in stage 1 as well as the one being issued
         v1     <= op_valid && !stop;
         exact  <= {1'b0, op_a} + {1'b0, op_b};
         approx <= approx_sum;
         if (go) begin
            lfsr <= (seed == 32'h0) ? 32'h1 : seed;
            cnt  <= '0;
         end else if (op_valid) begin
            lfsr <= lfsr_nx;
            last <= lfsr;
            cnt  <= cnt + CNT_W'(1);
         end
         if (go) begin
            err_count <= '0;
            err_sum   <= '0;
            err_max   <= '0;
         end else if (v1 && !stop) begin
            err_count <= err_count + CNT_W'(absdiff != '0);
            err_sum   <= err_sum + SW'(absdiff);
            err_max   <= (absdiff > err_max) ? absdiff : err_max;
         end
      end
   end
endmodule
